// File: rtl/pc_fetch_ctrl.sv
// Fetch-stage sequencer: owns the PC, issues one outstanding imem request at a time,
// drops stale responses after a redirect, and buffers one instruction for decode.
// Optional feature macro: PC_FETCH_CTRL_ALIGN_CHECK_EN (fault on misaligned redirect target).
module pc_fetch_ctrl #(
    parameter logic [31:0] BOOT_PC = 32'h1c000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        excp_flag_i,
    input  logic [31:0] excp_target_i,
    input  logic        branch_flag_i,
    input  logic [31:0] branch_target_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ready_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        inst_valid_o,
    input  logic        inst_ready_i,
    output logic [31:0] inst_o,
    output logic [31:0] inst_pc_o,
    output logic        inst_adef_o
);

    typedef enum logic [2:0] {BOOT, REQ, WAIT, DRAIN, HALT} state_t;

    state_t      state;
    logic [31:0] fetch_pc;
    logic [31:0] req_pc;
    logic        halt_pending;

    logic        redirect;
    logic        misaligned;
    logic        accept;
    logic        load_resp;
    logic [31:0] raw_target;
    logic [31:0] target;

    assign redirect   = excp_flag_i | branch_flag_i;
    assign raw_target = excp_flag_i ? excp_target_i : branch_target_i;

`ifdef PC_FETCH_CTRL_ALIGN_CHECK_EN
    assign target     = raw_target;
    assign misaligned = redirect & (raw_target[1:0] != 2'b00);
`else
    // Without the check, low address bits are simply discarded.
    assign target     = raw_target & ~32'h3;
    assign misaligned = 1'b0;
`endif

    // Request is gated so a response can never arrive while the buffer is still full.
    assign imem_req_o  = (state == REQ) & (~inst_valid_o | inst_ready_i);
    assign imem_addr_o = fetch_pc;
    assign accept      = imem_req_o & imem_ready_i;
    assign load_resp   = (state == WAIT) & imem_rvalid_i & ~redirect;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= BOOT;
            fetch_pc     <= BOOT_PC;
            req_pc       <= '0;
            halt_pending <= 1'b0;
            inst_valid_o <= 1'b0;
            inst_o       <= '0;
            inst_pc_o    <= '0;
            inst_adef_o  <= 1'b0;
        end else begin
            if (redirect) begin
                fetch_pc <= target;
            end else if (load_resp) begin
                fetch_pc <= req_pc + 32'd4;
            end

            if (accept) begin
                req_pc <= fetch_pc;
            end

            // A misaligned redirect replaces the buffer contents with a fault marker.
            if (redirect) begin
                inst_valid_o <= misaligned;
                if (misaligned) begin
                    inst_o      <= '0;
                    inst_pc_o   <= target;
                    inst_adef_o <= 1'b1;
                end
            end else if (load_resp) begin
                inst_valid_o <= 1'b1;
                inst_o       <= imem_rdata_i;
                inst_pc_o    <= req_pc;
                inst_adef_o  <= 1'b0;
            end else if (inst_valid_o & inst_ready_i) begin
                inst_valid_o <= 1'b0;
            end

            case (state)
                BOOT: begin
                    state <= misaligned ? HALT : REQ;
                end
                REQ: begin
                    if (accept) begin
                        state        <= redirect ? DRAIN : WAIT;
                        halt_pending <= misaligned;
                    end else if (misaligned) begin
                        state <= HALT;
                    end
                end
                WAIT: begin
                    if (redirect) begin
                        if (imem_rvalid_i) begin
                            state <= misaligned ? HALT : REQ;
                        end else begin
                            state        <= DRAIN;
                            halt_pending <= misaligned;
                        end
                    end else if (imem_rvalid_i) begin
                        state <= REQ;
                    end
                end
                DRAIN: begin
                    // The latest redirect decides where we land once the stale response is gone.
                    if (imem_rvalid_i) begin
                        state <= (redirect ? misaligned : halt_pending) ? HALT : REQ;
                    end else if (redirect) begin
                        halt_pending <= misaligned;
                    end
                end
                HALT: begin
                    if (redirect) begin
                        state <= misaligned ? HALT : REQ;
                    end
                end
                default: begin
                    state <= BOOT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Scoreboard bench for pc_fetch_ctrl: directed scenarios push expected requests and
// instructions; monitors pop and compare whenever the DUT presents them.
module tb_pc_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        excp_flag_i;
    logic [31:0] excp_target_i;
    logic        branch_flag_i;
    logic [31:0] branch_target_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ready_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        inst_valid_o;
    logic        inst_ready_i;
    logic [31:0] inst_o;
    logic [31:0] inst_pc_o;
    logic        inst_adef_o;

    always #5 clk = ~clk;

    pc_fetch_ctrl #(.BOOT_PC(32'h1c000000)) dut (
        .clk             (clk),
        .rst             (rst),
        .excp_flag_i     (excp_flag_i),
        .excp_target_i   (excp_target_i),
        .branch_flag_i   (branch_flag_i),
        .branch_target_i (branch_target_i),
        .imem_req_o      (imem_req_o),
        .imem_addr_o     (imem_addr_o),
        .imem_ready_i    (imem_ready_i),
        .imem_rvalid_i   (imem_rvalid_i),
        .imem_rdata_i    (imem_rdata_i),
        .inst_valid_o    (inst_valid_o),
        .inst_ready_i    (inst_ready_i),
        .inst_o          (inst_o),
        .inst_pc_o       (inst_pc_o),
        .inst_adef_o     (inst_adef_o)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        adef;
    } inst_t;

    int          vec_cnt = 0;
    int          err_cnt = 0;
    logic [31:0] exp_req_q[$];
    inst_t       exp_inst_q[$];
    int          mem_lat = 1;
    logic [31:0] poison_addr = 32'hffff_fff0;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h13579bdf;
    endfunction

    function automatic inst_t mk(input logic [31:0] pc, input logic [31:0] inst, input logic adef);
        inst_t e;
        e.pc   = pc;
        e.inst = inst;
        e.adef = adef;
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    // Request monitor: every accepted request must match the next expected address.
    always @(negedge clk) begin
        if (rst === 1'b1 && imem_req_o && imem_ready_i) begin
            if (exp_req_q.size() == 0) begin
                vec_cnt++;
                err_cnt++;
                $display("FAIL req_addr: unexpected request addr %h expected none", imem_addr_o);
            end else begin
                check("req_addr", imem_addr_o, exp_req_q.pop_front());
            end
        end
    end

    // Instruction monitor: every consumed instruction must match the next expected entry.
    always @(negedge clk) begin
        if (rst === 1'b1 && inst_valid_o && inst_ready_i) begin
            inst_t e;
            vec_cnt++;
            if (exp_inst_q.size() == 0) begin
                err_cnt++;
                $display("FAIL inst_out: unexpected pc %h inst %h adef %b expected none",
                         inst_pc_o, inst_o, inst_adef_o);
            end else begin
                e = exp_inst_q.pop_front();
                if ({inst_pc_o, inst_o, inst_adef_o} !== {e.pc, e.inst, e.adef}) begin
                    err_cnt++;
                    $display("FAIL inst_out: got pc %h inst %h adef %b expected pc %h inst %h adef %b",
                             inst_pc_o, inst_o, inst_adef_o, e.pc, e.inst, e.adef);
                end else begin
                    $display("ok   inst_out: pc %h inst %h adef %b", inst_pc_o, inst_o, inst_adef_o);
                end
            end
        end
    end

    // Memory model: one response mem_lat cycles after each acceptance.
    initial begin
        logic        acc;
        logic [31:0] acc_addr;
        logic [31:0] a;
        int          cnt;
        bit          pend;
        pend          = 1'b0;
        cnt           = 0;
        a             = '0;
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = '0;
        forever begin
            @(negedge clk);
            acc      = (rst === 1'b1) && imem_req_o && imem_ready_i;
            acc_addr = imem_addr_o;
            @(posedge clk);
            #1;
            imem_rvalid_i = 1'b0;
            if (acc) begin
                vec_cnt++;
                if (pend) begin
                    err_cnt++;
                    $display("FAIL outstanding: request %h accepted while %h pending, required none", acc_addr, a);
                end
                pend = 1'b1;
                a    = acc_addr;
                cnt  = mem_lat;
            end
            if (pend) begin
                cnt--;
                if (cnt <= 0) begin
                    imem_rvalid_i = 1'b1;
                    imem_rdata_i  = (a == poison_addr) ? 32'hdeadbeef : word_of(a);
                    pend          = 1'b0;
                end
            end
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_req_drain(input string name);
        int t = 0;
        while (exp_req_q.size() != 0 && t < 50) begin
            step();
            t++;
        end
        if (exp_req_q.size() != 0) begin
            vec_cnt++;
            err_cnt++;
            $display("FAIL %s: got %0d requests still pending expected 0", name, exp_req_q.size());
            exp_req_q.delete();
        end
    endtask

    task automatic wait_inst_drain(input string name);
        int t = 0;
        while (exp_inst_q.size() != 0 && t < 50) begin
            step();
            t++;
        end
        if (exp_inst_q.size() != 0) begin
            vec_cnt++;
            err_cnt++;
            $display("FAIL %s: got %0d instructions still pending expected 0", name, exp_inst_q.size());
            exp_inst_q.delete();
        end
    endtask

    task automatic check_at_negedge(input string name, input logic [31:0] act_sel, input logic [31:0] exp);
        @(negedge clk);
        case (act_sel)
            0: check(name, {31'd0, imem_req_o}, exp);
            1: check(name, {31'd0, inst_valid_o}, exp);
            2: check(name, inst_pc_o, exp);
            default: check(name, {31'd0, inst_adef_o}, exp);
        endcase
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst             = 1'b0;
        excp_flag_i     = 1'b0;
        excp_target_i   = '0;
        branch_flag_i   = 1'b0;
        branch_target_i = '0;
        imem_ready_i    = 1'b0;
        inst_ready_i    = 1'b1;
        step(3);

        // Reset values
        @(negedge clk);
        check("rst_req",   {31'd0, imem_req_o},   32'd0);
        check("rst_addr",  imem_addr_o,           32'h1c000000);
        check("rst_valid", {31'd0, inst_valid_o}, 32'd0);
        check("rst_inst",  inst_o,                32'd0);
        check("rst_pc",    inst_pc_o,             32'd0);
        check("rst_adef",  {31'd0, inst_adef_o},  32'd0);

        // Sequential fetch after reset, 1-cycle memory
        for (int i = 0; i < 3; i++) begin
            exp_req_q.push_back(32'h1c000000 + 32'(4 * i));
            exp_inst_q.push_back(mk(32'h1c000000 + 32'(4 * i), word_of(32'h1c000000 + 32'(4 * i)), 1'b0));
        end
        @(posedge clk);
        #1;
        rst          = 1'b1;
        imem_ready_i = 1'b1;
        @(negedge clk);
        check("req_cycle1", {31'd0, imem_req_o}, 32'd0);
        @(negedge clk);
        check("req_cycle2", {31'd0, imem_req_o}, 32'd1);
        @(posedge clk);
        #1;
        wait_req_drain("seq_req");
        imem_ready_i = 1'b0;
        wait_inst_drain("seq_inst");

        // Backpressure: full buffer blocks requests until decode is ready
        inst_ready_i = 1'b0;
        exp_req_q.push_back(32'h1c00000c);
        imem_ready_i = 1'b1;
        wait_req_drain("bp_req");
        step(4);
        check_at_negedge("bp_stall", 0, 32'd0);
        exp_req_q.push_back(32'h1c000010);
        exp_inst_q.push_back(mk(32'h1c00000c, word_of(32'h1c00000c), 1'b0));
        exp_inst_q.push_back(mk(32'h1c000010, word_of(32'h1c000010), 1'b0));
        inst_ready_i = 1'b1;
        wait_req_drain("bp_resume");
        imem_ready_i = 1'b0;
        wait_inst_drain("bp_inst");

        // Branch in WAIT; the stale 0xdeadbeef response arrives 3 cycles later
        poison_addr = 32'h1c000014;
        mem_lat     = 4;
        exp_req_q.push_back(32'h1c000014);
        imem_ready_i = 1'b1;
        wait_req_drain("stale_req");
        exp_req_q.push_back(32'h1c000100);
        exp_inst_q.push_back(mk(32'h1c000100, word_of(32'h1c000100), 1'b0));
        branch_flag_i   = 1'b1;
        branch_target_i = 32'h1c000100;
        step();
        branch_flag_i = 1'b0;
        mem_lat       = 1;
        wait_req_drain("stale_redirect");
        imem_ready_i = 1'b0;
        wait_inst_drain("stale_inst");
        poison_addr = 32'hffff_fff0;

        // Exception wins over branch in the same cycle
        exp_req_q.push_back(32'h1c008000);
        exp_inst_q.push_back(mk(32'h1c008000, word_of(32'h1c008000), 1'b0));
        excp_flag_i     = 1'b1;
        excp_target_i   = 32'h1c008000;
        branch_flag_i   = 1'b1;
        branch_target_i = 32'h1c000100;
        step();
        excp_flag_i   = 1'b0;
        branch_flag_i = 1'b0;
        imem_ready_i  = 1'b1;
        wait_req_drain("prio_req");
        imem_ready_i = 1'b0;
        wait_inst_drain("prio_inst");

        // Redirect clears a full buffer even when decode is not ready
        inst_ready_i = 1'b0;
        exp_req_q.push_back(32'h1c008004);
        imem_ready_i = 1'b1;
        wait_req_drain("flush_req");
        imem_ready_i = 1'b0;
        step(2);
        check_at_negedge("flush_full", 1, 32'd1);
        branch_flag_i   = 1'b1;
        branch_target_i = 32'h1c000200;
        step();
        branch_flag_i = 1'b0;
        check_at_negedge("flush_empty", 1, 32'd0);
        inst_ready_i = 1'b1;

        // Redirect coincident with acceptance: that response is dropped
        exp_req_q.push_back(32'h1c000200);
        exp_req_q.push_back(32'h1c000300);
        exp_inst_q.push_back(mk(32'h1c000300, word_of(32'h1c000300), 1'b0));
        imem_ready_i    = 1'b1;
        branch_flag_i   = 1'b1;
        branch_target_i = 32'h1c000300;
        step();
        branch_flag_i = 1'b0;
        wait_req_drain("coinc_req");
        imem_ready_i = 1'b0;
        wait_inst_drain("coinc_inst");

`ifdef PC_FETCH_CTRL_ALIGN_CHECK_EN
        // Misaligned branch target faults and halts fetch until an exception redirect
        exp_inst_q.push_back(mk(32'h1c000102, 32'h0, 1'b1));
        branch_flag_i   = 1'b1;
        branch_target_i = 32'h1c000102;
        step();
        branch_flag_i = 1'b0;
        imem_ready_i  = 1'b1;
        step(5);
        check_at_negedge("halt_noreq", 0, 32'd0);
        wait_inst_drain("adef_inst");
        exp_req_q.push_back(32'h1c008000);
        exp_inst_q.push_back(mk(32'h1c008000, word_of(32'h1c008000), 1'b0));
        excp_flag_i   = 1'b1;
        excp_target_i = 32'h1c008000;
        step();
        excp_flag_i = 1'b0;
        wait_req_drain("halt_exit_req");
        imem_ready_i = 1'b0;
        wait_inst_drain("halt_exit_inst");
`else
        // Misaligned branch target has its low bits dropped
        exp_req_q.push_back(32'h1c000400);
        exp_inst_q.push_back(mk(32'h1c000400, word_of(32'h1c000400), 1'b0));
        branch_flag_i   = 1'b1;
        branch_target_i = 32'h1c000402;
        step();
        branch_flag_i = 1'b0;
        imem_ready_i  = 1'b1;
        wait_req_drain("trunc_req");
        imem_ready_i = 1'b0;
        wait_inst_drain("trunc_inst");
        check_at_negedge("trunc_adef", 3, 32'd0);
`endif

        step(3);
        check("left_req",  32'(exp_req_q.size()),  32'd0);
        check("left_inst", 32'(exp_inst_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
